spr_dma_arb: RTL
================

Name: spr_dma_arb

Overview:
- Bus arbiter directly downstream of the sprite-DMA master.
- Multiplexes the CPU and the sprite-DMA request port onto the single CPU-side memory bus.
- Halts the CPU through a RDY line, applies NES-style odd-cycle alignment, then grants the DMA one bus access per gnt pulse.
- Returns the bus to the CPU when the DMA drops its request.

Parameters:
- RD_LAT, 0, bus read latency in cycles (legal 0..3); every DMA access occupies RD_LAT+1 cycles.
- ALIGN_EN, 1, when 1 insert one extra idle cycle if the halt completes on an odd bus cycle.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_cpu_addr  in  16  CPU address
- i_cpu_wn  in  1  CPU write strobe, active-low
- i_cpu_wdata  in  8  CPU write data
- o_cpu_rdata  out  8  read data to CPU
- o_cpu_rdy  out  1  CPU ready; 0 freezes the CPU core
- i_dma_req  in  1  DMA request, level, held until last gnt
- o_dma_gnt  out  1  one-cycle pulse: DMA access complete, read data valid this cycle
- i_dma_addr  in  16  DMA address
- i_dma_wn  in  1  DMA write strobe, active-low
- i_dma_wdata  in  8  DMA write data
- o_dma_rdata  out  8  read data to DMA
- o_bus_addr  out  16  shared bus address
- o_bus_wn  out  1  shared bus write strobe, active-low
- o_bus_wdata  out  8  shared bus write data
- i_bus_rdata  in  8  shared bus read data, valid RD_LAT cycles after address

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. i_clk and i_rst.
- Reset values:
  - state=CPU_OWN, o_cpu_rdy=1, o_dma_gnt=0, parity bit=0 (even).
  - Bus driven from CPU ports.
- Parity bit: toggles every cycle out of reset, regardless of state.
- o_cpu_rdata and o_dma_rdata are both wired to i_bus_rdata.
- States:
  - CPU_OWN
    - Bus = CPU ports, o_cpu_rdy=1.
    - i_dma_req=1 -> HALT next cycle; the CPU still owns the bus in the sampling cycle.
  - HALT
    - o_cpu_rdy=0; bus idle (addr 16'h0, wn=1, wdata 0).
    - If i_dma_req=0 -> CPU_OWN.
    - Else, if ALIGN_EN=1 and parity=1 -> ALIGN.
    - Else -> DMA_ACC with phase counter=0.
  - ALIGN
    - o_cpu_rdy=0, bus idle.
    - i_dma_req=0 -> CPU_OWN; else -> DMA_ACC with phase=0.
  - DMA_ACC
    - o_cpu_rdy=0; bus = DMA ports, held stable for the whole access.
    - 2-bit phase counter increments each cycle.
    - o_dma_gnt=1 combinationally when phase==RD_LAT; phase then clears.
    - The cycle after gnt: i_dma_req=1 -> new access in DMA_ACC; i_dma_req=0 -> CPU_OWN, with o_cpu_rdy=1 in that same cycle.
- RD_LAT=0: gnt is high every DMA_ACC cycle. A 256-byte sprite DMA (512 accesses) stalls the CPU 513 cycles (even start) or 514 cycles (odd start).
- Request drop mid-access (phase<RD_LAT): abort with no gnt, go to CPU_OWN next cycle.
- Writes use the same RD_LAT+1 timing; o_bus_wn is low for every cycle of the access.
- CPU write to 16'h4014 arriving with i_dma_req already high: the CPU access completes normally in CPU_OWN. The arbiter never blocks the current CPU cycle.
- o_dma_gnt is never high outside DMA_ACC.
- Reset asserted mid-DMA: immediately CPU_OWN, rdy=1, gnt=0, and the phase counter cleared.
- Phase counter width: 2 bits. RD_LAT>3 is illegal; report it with an elaboration-time check.

Decomposition:
- Shared package ppu_bus_pkg holds:
  - 3-bit state encodings ARB_CPU_OWN=0, ARB_HALT=1, ARB_ALIGN=2, ARB_DMA_ACC=3.
  - Constant SPR_DMA_REG=16'h4014.
  - Constant BUS_IDLE_ADDR=16'h0.
- No sub-module: FSM, parity bit, phase counter and output mux form one block of about 150-250 lines.

Test Plan:
- Reset: i_rst pulse mid-DMA_ACC -> o_cpu_rdy=1 and o_dma_gnt=0 immediately, bus = CPU addr on the next edge.
- Even-cycle start, RD_LAT=0, full 256-byte DMA from page 8'h02 -> 512 gnt pulses. o_cpu_rdy low exactly 513 cycles. Bus shows 0200,2004,0201,2004…02FF,2004.
- Odd-cycle start, ALIGN_EN=1 -> ALIGN is visited once. o_cpu_rdy low 514 cycles; first DMA address appears 2 cycles after HALT entry.
- RD_LAT=2, single read of 16'h0300 returning 8'hA5 -> address held 3 cycles. gnt occurs in the third cycle with o_dma_rdata=8'hA5.
- i_dma_req dropped during HALT or mid-access with RD_LAT=1 -> no gnt, CPU_OWN next cycle, o_cpu_rdy=1.
- CPU write 8'h07 to 16'h4014 in the cycle i_dma_req rises -> o_bus_wn=0, addr 4014, wdata 07 that cycle; HALT follows.

Source files
------------

// File: rtl/ppu_bus_pkg.sv
// Shared definitions for the PPU/CPU bus fabric.
// Holds the sprite-DMA arbiter state encoding and the fixed bus addresses
// used by the arbiter and its bench.
package ppu_bus_pkg;

  typedef enum logic [2:0] {
    ARB_CPU_OWN = 3'd0,
    ARB_HALT    = 3'd1,
    ARB_ALIGN   = 3'd2,
    ARB_DMA_ACC = 3'd3
  } arb_state_e;

  // CPU-visible register that kicks off a sprite DMA.
  localparam logic [15:0] SPR_DMA_REG   = 16'h4014;
  // Address driven while nobody owns the bus.
  localparam logic [15:0] BUS_IDLE_ADDR = 16'h0000;

endpackage

// File: rtl/spr_dma_arb.sv
// Sprite-DMA bus arbiter.
// Multiplexes the CPU and the sprite-DMA master onto the single CPU-side bus.
// On a DMA request the CPU is halted via o_cpu_rdy, an optional idle cycle
// aligns the first access to an even bus cycle, and the DMA then receives one
// bus access of RD_LAT+1 cycles per o_dma_gnt pulse.
//
// Ports:
//   i_clk, i_rst                       clock, async active-high reset
//   i_cpu_addr/wn/wdata, o_cpu_rdata   CPU request port
//   o_cpu_rdy                          0 freezes the CPU core
//   i_dma_req, o_dma_gnt               DMA request level / access-done pulse
//   i_dma_addr/wn/wdata, o_dma_rdata   DMA request port
//   o_bus_addr/wn/wdata, i_bus_rdata   shared memory bus
module spr_dma_arb
  import ppu_bus_pkg::*;
#(
  parameter int unsigned RD_LAT   = 0,
  parameter bit          ALIGN_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_wn,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_rdy,
  input  logic        i_dma_req,
  output logic        o_dma_gnt,
  input  logic [15:0] i_dma_addr,
  input  logic        i_dma_wn,
  input  logic [7:0]  i_dma_wdata,
  output logic [7:0]  o_dma_rdata,
  output logic [15:0] o_bus_addr,
  output logic        o_bus_wn,
  output logic [7:0]  o_bus_wdata,
  input  logic [7:0]  i_bus_rdata
);

  if (RD_LAT > 3) begin : g_bad_rd_lat
    $error("spr_dma_arb: RD_LAT must be in 0..3 (2-bit phase counter)");
  end

  localparam logic [1:0] LAST_PHASE = 2'(RD_LAT);

  arb_state_e state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic       parity_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ARB_CPU_OWN;
      phase_q  <= 2'd0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      parity_q <= ~parity_q;
    end
  end

  // Read data needs no steering: only the current bus owner samples it.
  assign o_cpu_rdata = i_bus_rdata;
  assign o_dma_rdata = i_bus_rdata;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    o_cpu_rdy   = 1'b0;
    o_dma_gnt   = 1'b0;
    o_bus_addr  = BUS_IDLE_ADDR;
    o_bus_wn    = 1'b1;
    o_bus_wdata = 8'h00;

    case (state_q)
      ARB_CPU_OWN: begin
        // The CPU keeps the bus in the cycle the request is sampled, so a
        // write to SPR_DMA_REG always completes.
        o_cpu_rdy   = 1'b1;
        o_bus_addr  = i_cpu_addr;
        o_bus_wn    = i_cpu_wn;
        o_bus_wdata = i_cpu_wdata;
        phase_d     = 2'd0;
        if (i_dma_req) state_d = ARB_HALT;
      end

      ARB_HALT: begin
        phase_d = 2'd0;
        if (!i_dma_req) begin
          state_d = ARB_CPU_OWN;
        end else if (ALIGN_EN && parity_q) begin
          state_d = ARB_ALIGN;
        end else begin
          state_d = ARB_DMA_ACC;
        end
      end

      ARB_ALIGN: begin
        phase_d = 2'd0;
        state_d = i_dma_req ? ARB_DMA_ACC : ARB_CPU_OWN;
      end

      ARB_DMA_ACC: begin
        if (!i_dma_req) begin
          state_d = ARB_CPU_OWN;
          phase_d = 2'd0;
          if (phase_q == 2'd0) begin
            // No access in flight (request dropped after the last gnt):
            // hand the bus back to the CPU in this very cycle.
            o_cpu_rdy   = 1'b1;
            o_bus_addr  = i_cpu_addr;
            o_bus_wn    = i_cpu_wn;
            o_bus_wdata = i_cpu_wdata;
          end else begin
            // Aborted access: keep the DMA address stable until the end.
            o_bus_addr  = i_dma_addr;
            o_bus_wn    = i_dma_wn;
            o_bus_wdata = i_dma_wdata;
          end
        end else begin
          o_bus_addr  = i_dma_addr;
          o_bus_wn    = i_dma_wn;
          o_bus_wdata = i_dma_wdata;
          if (phase_q == LAST_PHASE) begin
            o_dma_gnt = 1'b1;
            phase_d   = 2'd0;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = ARB_CPU_OWN;
        phase_d = 2'd0;
      end
    endcase
  end

endmodule
